// File: rtl/thermal_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : thermal_fb_writer
//  Description : Maps a 32x24 signed sensor stream to 8-bit intensity and
//                writes each sample as a 5x5 block into one bank of a
//                double-buffered 160x120 framebuffer.
//  Revision    : 1.0  initial release
// ============================================================================
module thermal_fb_writer #(
    parameter int P_SRC_W  = 32,
    parameter int P_SRC_H  = 24,
    parameter int P_SCALE  = 5,
    parameter int P_DATA_W = 16,
    parameter int P_PIX_W  = 8,
    parameter int P_FB_W   = P_SRC_W * P_SCALE,
    parameter int P_FB_H   = P_SRC_H * P_SCALE,
    parameter int P_ADDR_W = $clog2(P_FB_W * P_FB_H)
) (
    input  logic                i_clk_pixel,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_sof,
    input  logic [P_DATA_W-1:0] i_data,
    input  logic [P_DATA_W-1:0] i_t_min,
    input  logic [3:0]          i_shift,
    output logic                o_we,
    output logic [P_ADDR_W-1:0] o_addr,
    output logic [P_PIX_W-1:0]  o_wdata,
    output logic                o_bank,
    output logic                o_frame_done,
    output logic                o_err_sync
);

    localparam int C_SC_W = (P_SCALE > 1) ? $clog2(P_SCALE) : 1;
    localparam int C_PX_W = (P_SRC_W > 1) ? $clog2(P_SRC_W) : 1;
    localparam int C_PY_W = (P_SRC_H > 1) ? $clog2(P_SRC_H) : 1;

    localparam logic [C_SC_W-1:0]   C_SC_LAST   = C_SC_W'(P_SCALE - 1);
    localparam logic [C_PX_W-1:0]   C_PX_LAST   = C_PX_W'(P_SRC_W - 1);
    localparam logic [C_PY_W-1:0]   C_PY_LAST   = C_PY_W'(P_SRC_H - 1);
    localparam logic [P_ADDR_W-1:0] C_ONE       = P_ADDR_W'(1);
    localparam logic [P_ADDR_W-1:0] C_COL_STEP  = P_ADDR_W'(P_SCALE);
    localparam logic [P_ADDR_W-1:0] C_ROW_STEP  = P_ADDR_W'(P_FB_W - P_SCALE + 1);
    localparam logic [P_ADDR_W-1:0] C_LINE_STEP = P_ADDR_W'(P_FB_W * P_SCALE);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic                ready_nxt, we_nxt, bank_nxt, done_nxt, err_nxt;
    logic [P_ADDR_W-1:0] addr_nxt;
    logic [P_PIX_W-1:0]  wdata_nxt;
    logic [C_PX_W-1:0]   px, px_nxt;
    logic [C_PY_W-1:0]   py, py_nxt;
    logic [C_SC_W-1:0]   dx, dx_nxt, dy, dy_nxt;
    // Address of the current block's top-left pixel and of its source line.
    logic [P_ADDR_W-1:0] blk_base, blk_base_nxt;
    logic [P_ADDR_W-1:0] line_base, line_base_nxt;

    logic [P_DATA_W:0]   diff;
    logic [P_DATA_W:0]   shifted;
    logic [P_PIX_W-1:0]  mapped;

    // Sign-extended subtraction cannot overflow; a set MSB means below floor.
    always_comb begin
        diff    = {i_data[P_DATA_W-1], i_data} - {i_t_min[P_DATA_W-1], i_t_min};
        shifted = diff >> i_shift;
        if (diff[P_DATA_W]) begin
            mapped = '0;
        end else if (|shifted[P_DATA_W:P_PIX_W]) begin
            mapped = '1;
        end else begin
            mapped = shifted[P_PIX_W-1:0];
        end
    end

    always_comb begin
        state_nxt     = state;
        ready_nxt     = o_ready;
        we_nxt        = o_we;
        addr_nxt      = o_addr;
        wdata_nxt     = o_wdata;
        bank_nxt      = o_bank;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        px_nxt        = px;
        py_nxt        = py;
        dx_nxt        = dx;
        dy_nxt        = dy;
        blk_base_nxt  = blk_base;
        line_base_nxt = line_base;

        case (state)
            S_IDLE: begin
                ready_nxt = 1'b1;
                if (o_ready && i_valid) begin
                    ready_nxt = 1'b0;
                    we_nxt    = 1'b1;
                    wdata_nxt = mapped;
                    dx_nxt    = '0;
                    dy_nxt    = '0;
                    state_nxt = S_WRITE;
                    if (i_sof) begin
                        err_nxt       = (px != '0) || (py != '0);
                        px_nxt        = '0;
                        py_nxt        = '0;
                        blk_base_nxt  = '0;
                        line_base_nxt = '0;
                        addr_nxt      = '0;
                    end else begin
                        addr_nxt = blk_base;
                    end
                end
            end
            S_WRITE: begin
                if (dx != C_SC_LAST) begin
                    dx_nxt   = dx + C_SC_W'(1);
                    addr_nxt = o_addr + C_ONE;
                end else if (dy != C_SC_LAST) begin
                    dx_nxt   = '0;
                    dy_nxt   = dy + C_SC_W'(1);
                    addr_nxt = o_addr + C_ROW_STEP;
                end else begin
                    dx_nxt    = '0;
                    dy_nxt    = '0;
                    we_nxt    = 1'b0;
                    ready_nxt = 1'b1;
                    state_nxt = S_IDLE;
                    if (px != C_PX_LAST) begin
                        px_nxt       = px + C_PX_W'(1);
                        blk_base_nxt = blk_base + C_COL_STEP;
                    end else if (py != C_PY_LAST) begin
                        px_nxt        = '0;
                        py_nxt        = py + C_PY_W'(1);
                        line_base_nxt = line_base + C_LINE_STEP;
                        blk_base_nxt  = line_base + C_LINE_STEP;
                    end else begin
                        // Frame complete: hand the finished bank to the display.
                        px_nxt        = '0;
                        py_nxt        = '0;
                        line_base_nxt = '0;
                        blk_base_nxt  = '0;
                        bank_nxt      = ~o_bank;
                        done_nxt      = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            state        <= S_IDLE;
            o_ready      <= 1'b0;
            o_we         <= 1'b0;
            o_addr       <= '0;
            o_wdata      <= '0;
            o_bank       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err_sync   <= 1'b0;
            px           <= '0;
            py           <= '0;
            dx           <= '0;
            dy           <= '0;
            blk_base     <= '0;
            line_base    <= '0;
        end else begin
            state        <= state_nxt;
            o_ready      <= ready_nxt;
            o_we         <= we_nxt;
            o_addr       <= addr_nxt;
            o_wdata      <= wdata_nxt;
            o_bank       <= bank_nxt;
            o_frame_done <= done_nxt;
            o_err_sync   <= err_nxt;
            px           <= px_nxt;
            py           <= py_nxt;
            dx           <= dx_nxt;
            dy           <= dy_nxt;
            blk_base     <= blk_base_nxt;
            line_base    <= line_base_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_thermal_fb_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_thermal_fb_writer
//  Description : Randomised stream against a cycle-indexed behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_thermal_fb_writer;

    localparam int SW = 32, SH = 24, SC = 5, FBW = 160, NPIX = 19200;
    localparam int NEVER = 1 << 30;

    logic               clk = 1'b0, rst = 1'b1, valid = 1'b0, sof = 1'b0;
    logic signed [15:0] data = '0, tmin = '0;
    logic [3:0]         shift = '0;
    logic               ready, we, bank, done, err;
    logic [14:0]        addr;
    logic [7:0]         wdata;

    thermal_fb_writer dut (
        .i_clk_pixel (clk),   .i_rst      (rst),   .i_valid (valid),
        .o_ready     (ready), .i_sof      (sof),   .i_data  (data),
        .i_t_min     (tmin),  .i_shift    (shift), .o_we    (we),
        .o_addr      (addr),  .o_wdata    (wdata), .o_bank  (bank),
        .o_frame_done(done),  .o_err_sync (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- behavioural model, indexed by output cycle ----------------
    int exp_addr[int];
    int exp_data[int];
    bit exp_done[int];
    bit exp_err[int];
    int mpx = 0, mpy = 0;
    int rst_lo = 1, rst_hi = NEVER, ready_from = NEVER;

    function automatic int map_px(int d, int tm, int sh);
        int v;
        v = d - tm;
        if (v < 0) return 0;
        v = v >> sh;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_accept(input int n, input int d, input int tm, input int sh, input bit s);
        int v, k;
        v = map_px(d, tm, sh);
        k = 0;
        if (s) begin
            if (mpx != 0 || mpy != 0) exp_err[n + 1] = 1'b1;
            mpx = 0;
            mpy = 0;
        end
        for (int yy = 0; yy < SC; yy++)
            for (int xx = 0; xx < SC; xx++) begin
                exp_addr[n + 1 + k] = (mpy * SC + yy) * FBW + mpx * SC + xx;
                exp_data[n + 1 + k] = v;
                k++;
            end
        mpx++;
        if (mpx == SW) begin
            mpx = 0;
            mpy++;
            if (mpy == SH) begin
                mpy = 0;
                exp_done[n + 1 + SC * SC] = 1'b1;
            end
        end
    endtask

    task automatic model_reset(input int c);
        for (int k = c + 1; k < c + 40; k++) begin
            exp_addr.delete(k); exp_data.delete(k);
            exp_done.delete(k); exp_err.delete(k);
        end
        rst_lo = c + 1;
        rst_hi = NEVER;
        mpx = 0;
        mpy = 0;
    endtask

    task automatic model_release(input int r);
        rst_hi     = r;
        ready_from = r + 1;
    endtask

    // ---------------- compare process + observation bookkeeping ----------------
    bit exp_bank = 1'b0;
    int seen_q[$];
    int last_data = 0, last_addr = 0, cnt_done = 0, cnt_err = 0, n_unique = 0, n_dup = 0;
    bit seen_map[NPIX];
    bit clear_map = 1'b0;

    always @(negedge clk) begin
        bit inr, wexp;
        if (clear_map) begin
            foreach (seen_map[i]) seen_map[i] = 1'b0;
            n_unique = 0;
            n_dup = 0;
            clear_map = 1'b0;
        end
        if (cyc >= 1) begin
            inr  = (cyc >= rst_lo) && (cyc <= rst_hi);
            wexp = exp_addr.exists(cyc);
            if (cyc == rst_lo) exp_bank = 1'b0;
            if (exp_done.exists(cyc)) exp_bank = ~exp_bank;
            chk("we", we, wexp);
            chk("ready", ready, !inr && cyc >= ready_from && !wexp);
            chk("frame_done", done, exp_done.exists(cyc));
            chk("err_sync", err, exp_err.exists(cyc));
            chk("bank", bank, exp_bank);
            if (wexp) begin
                chk("addr", addr, exp_addr[cyc]);
                chk("wdata", wdata, exp_data[cyc]);
            end
            if (inr) begin
                chk("rst_addr", addr, 0);
                chk("rst_wdata", wdata, 0);
            end
            if (we) begin
                seen_q.push_back(int'(addr));
                last_data = int'(wdata);
                last_addr = int'(addr);
                if (int'(addr) < NPIX) begin
                    if (seen_map[addr]) n_dup++;
                    else n_unique++;
                    seen_map[addr] = 1'b1;
                end
            end
            if (done) cnt_done++;
            if (err) cnt_err++;
        end
    end

    // ---------------- driver ----------------
    task automatic send_beat(input int d, input int tm, input int sh, input bit s,
                             input int gap, output int acc);
        acc = -1;
        repeat (gap) begin @(posedge clk); #1; end
        valid = 1'b1; data = 16'(d); tmin = 16'(tm); shift = 4'(sh); sof = s;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (ready) begin
                acc = cyc;
                model_accept(cyc, d, tm, sh, s);
                break;
            end
            @(posedge clk); #1;
        end
        if (acc < 0) chk("beat_accept_timeout", 0, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        sof   = 1'b0;
        data  = 16'($urandom);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic rand_beat(input bit s, output int acc);
        int d, tm, sh;
        d  = int'($urandom_range(0, 65535)) - 32768;
        tm = int'($urandom_range(0, 65535)) - 32768;
        sh = int'($urandom_range(0, 15));
        send_beat(d, tm, sh, s, int'($urandom_range(0, 3)), acc);
    endtask

    int blk2[25] = '{0, 1, 2, 3, 4, 160, 161, 162, 163, 164, 320, 321, 322, 323, 324,
                     480, 481, 482, 483, 484, 640, 641, 642, 643, 644};
    int sat_d[5] = '{900, 1400, 3000, -32768, 32767};
    int sat_t[5] = '{1000, 1000, 1000, 1000, -32768};
    int sat_s[5] = '{2, 2, 2, 2, 0};
    int sat_e[5] = '{0, 100, 255, 0, 255};

    initial begin
        int acc, e0;
        // 1. reset
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("reset_ready", ready, 0); chk("reset_we", we, 0); chk("reset_bank", bank, 0);
        chk("reset_done", done, 0);   chk("reset_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_release(cyc);
        @(negedge clk);
        chk("ready_after_release", ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_cycle_after_release", ready, 1);
        @(posedge clk); #1;

        // 2. single block
        seen_q.delete();
        send_beat(100, 0, 0, 1'b1, 0, acc);
        wait_idle();
        chk("blk_count", seen_q.size(), 25);
        for (int i = 0; i < 25 && i < seen_q.size(); i++) chk("blk_addr", seen_q[i], blk2[i]);
        chk("blk_data", last_data, 100);

        // 3. mapping boundaries
        for (int i = 0; i < 5; i++) begin
            send_beat(sat_d[i], sat_t[i], sat_s[i], 1'b0, 1, acc);
            wait_idle();
            chk("sat_value", last_data, sat_e[i]);
        end

        // 4. two full frames with random gaps
        clear_map = 1'b1;
        @(posedge clk); #1;
        cnt_done = 0;
        for (int i = 0; i < SW * SH; i++) rand_beat(i == 0, acc);
        wait_idle();
        chk("f1_done_count", cnt_done, 1);
        chk("f1_bank", bank, 1);
        chk("f1_last_addr", last_addr, 19199);
        chk("f1_unique_addrs", n_unique, NPIX);
        chk("f1_dup_addrs", n_dup, 0);
        for (int i = 0; i < SW * SH; i++) rand_beat(1'b0, acc);
        wait_idle();
        chk("f2_done_count", cnt_done, 2);
        chk("f2_bank", bank, 0);

        // 5. early sof on sample 11
        for (int i = 0; i < 11; i++) rand_beat(1'b0, acc);
        wait_idle();
        e0 = cnt_err;
        seen_q.delete();
        send_beat(5000, 0, 4, 1'b1, 0, acc);
        wait_idle();
        chk("sof_err_count", cnt_err - e0, 1);
        chk("sof_first_addr", seen_q.size() > 0 ? seen_q[0] : -1, 0);
        chk("sof_row1_addr", seen_q.size() > 5 ? seen_q[5] : -1, 160);
        chk("sof_bank", bank, 0);

        // 6. reset during write 12 of a block
        send_beat(2000, 100, 3, 1'b0, 0, acc);
        while (cyc < acc + 12) begin @(posedge clk); #1; end
        rst = 1'b1;
        model_reset(cyc);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_we", we, 0); chk("midrst_addr", addr, 0); chk("midrst_bank", bank, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_release(cyc);
        seen_q.delete();
        send_beat(300, 0, 1, 1'b0, 0, acc);
        wait_idle();
        chk("postrst_first_addr", seen_q.size() > 0 ? seen_q[0] : -1, 0);
        chk("postrst_count", seen_q.size(), 25);
        chk("postrst_data", last_data, 150);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
